// File: rtl/swt16_pkg.sv
// Shared defaults and the aux result entry layout for the register-file write arbiter.
package swt16_pkg;

  localparam int DEF_IALU_WORD_WIDTH = 16;
  localparam int DEF_REG_IDX_WIDTH   = 4;
  localparam int DEF_AUX_FIFO_DEPTH  = 2;
  localparam int DEF_STARVE_LIMIT    = 4;

  // One queued aux result: live bit, destination register, data.
  typedef struct packed {
    logic                           live;
    logic [DEF_REG_IDX_WIDTH-1:0]   idx;
    logic [DEF_IALU_WORD_WIDTH-1:0] res;
  } aux_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle for the write arbiter: writeback request, aux handshake and write-port outputs.
interface regfile_write_arbiter_if
  import swt16_pkg::*;
#(
  parameter int IALU_WORD_WIDTH = DEF_IALU_WORD_WIDTH,
  parameter int REG_IDX_WIDTH   = DEF_REG_IDX_WIDTH
);

  logic                            in_wb_act_write_res_to_reg;
  logic [IALU_WORD_WIDTH-1:0]      in_wb_res;
  logic [REG_IDX_WIDTH-1:0]        in_wb_res_reg_idx;
  logic                            in_aux_valid;
  logic [IALU_WORD_WIDTH-1:0]      in_aux_res;
  logic [REG_IDX_WIDTH-1:0]        in_aux_res_reg_idx;
  logic                            out_aux_ready;
  logic                            out_act_write_res_to_reg;
  logic [IALU_WORD_WIDTH-1:0]      out_res;
  logic [REG_IDX_WIDTH-1:0]        out_res_reg_idx;
  logic                            out_stall_pipe;
  logic [(2**REG_IDX_WIDTH)-1:0]   out_pending_reg_mask;

  modport master (
    output in_wb_act_write_res_to_reg, in_wb_res, in_wb_res_reg_idx,
    output in_aux_valid, in_aux_res, in_aux_res_reg_idx,
    input  out_aux_ready, out_act_write_res_to_reg, out_res, out_res_reg_idx,
    input  out_stall_pipe, out_pending_reg_mask
  );

  modport slave (
    input  in_wb_act_write_res_to_reg, in_wb_res, in_wb_res_reg_idx,
    input  in_aux_valid, in_aux_res, in_aux_res_reg_idx,
    output out_aux_ready, out_act_write_res_to_reg, out_res, out_res_reg_idx,
    output out_stall_pipe, out_pending_reg_mask
  );

endinterface

// File: rtl/aux_result_fifo.sv
// In-order aux result queue with per-entry live bits, kill-by-index and a pending-register mask.
module aux_result_fifo
  import swt16_pkg::*;
#(
  parameter int IALU_WORD_WIDTH = DEF_IALU_WORD_WIDTH,
  parameter int REG_IDX_WIDTH   = DEF_REG_IDX_WIDTH,
  parameter int AUX_FIFO_DEPTH  = DEF_AUX_FIFO_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [REG_IDX_WIDTH-1:0]      push_idx_i,
  input  logic [IALU_WORD_WIDTH-1:0]    push_res_i,
  input  logic                          pop_i,
  input  logic                          kill_vld_i,
  input  logic [REG_IDX_WIDTH-1:0]      kill_idx_i,
  output logic                          ready_o,
  output logic                          head_vld_o,
  output logic                          head_live_o,
  output logic [IALU_WORD_WIDTH-1:0]    head_res_o,
  output logic [REG_IDX_WIDTH-1:0]      head_idx_o,
  output logic [(2**REG_IDX_WIDTH)-1:0] mask_o
);

  localparam int PW = $clog2(AUX_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(AUX_FIFO_DEPTH);

  logic [IALU_WORD_WIDTH-1:0] res_q [AUX_FIFO_DEPTH];
  logic [REG_IDX_WIDTH-1:0]   idx_q [AUX_FIFO_DEPTH];
  logic [AUX_FIFO_DEPTH-1:0]  live_q, live_d;
  logic [PW-1:0]              rd_q, wr_q;
  logic [CW-1:0]              cnt_q, cnt_d;

  assign ready_o     = (cnt_q < DEPTH_C);
  assign head_vld_o  = (cnt_q != '0);
  assign head_live_o = live_q[rd_q];
  assign head_res_o  = res_q[rd_q];
  assign head_idx_o  = idx_q[rd_q];
  assign cnt_d       = cnt_q + CW'(push_i) - CW'(pop_i);

  // Next live bits: kill older matches, retire the popped slot, mark the new entry live.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < AUX_FIFO_DEPTH; i++) begin
      if (kill_vld_i && (idx_q[i] == kill_idx_i)) live_d[i] = 1'b0;
      if (push_i && (idx_q[i] == push_idx_i))     live_d[i] = 1'b0;
    end
    if (pop_i)  live_d[rd_q] = 1'b0;
    if (push_i) live_d[wr_q] = 1'b1;
  end

  // Registers still holding a live queued write.
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < AUX_FIFO_DEPTH; i++) begin
      if (live_q[i]) mask_o[idx_q[i]] = 1'b1;
    end
  end

  // Pointer, occupancy and live-bit state; reset discards everything queued.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      live_q <= '0;
    end else begin
      live_q <= live_d;
      cnt_q  <= cnt_d;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      if (push_i) wr_q <= wr_q + 1'b1;
    end
  end

  // Entry payload storage, written on accepted push only.
  always_ff @(posedge clock) begin
    if (push_i) begin
      res_q[wr_q] <= push_res_i;
      idx_q[wr_q] <= push_idx_i;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single register-file write port shared between writeback (priority) and a queued aux source.
module regfile_write_arbiter
  import swt16_pkg::*;
#(
  parameter int IALU_WORD_WIDTH = DEF_IALU_WORD_WIDTH,
  parameter int REG_IDX_WIDTH   = DEF_REG_IDX_WIDTH,
  parameter int AUX_FIFO_DEPTH  = DEF_AUX_FIFO_DEPTH,
  parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
  input logic              clock,
  input logic              reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic                          fifo_ready, head_vld, head_live, push, pop, head_grant;
  logic [IALU_WORD_WIDTH-1:0]    head_res, wr_res;
  logic [REG_IDX_WIDTH-1:0]      head_idx, wr_idx;
  logic [(2**REG_IDX_WIDTH)-1:0] fifo_mask;
  logic                          wr_en;
  logic [SW-1:0]                 starve_q, starve_d;

  assign push = bus.in_aux_valid && fifo_ready && !reset;

  aux_result_fifo #(
    .IALU_WORD_WIDTH(IALU_WORD_WIDTH),
    .REG_IDX_WIDTH  (REG_IDX_WIDTH),
    .AUX_FIFO_DEPTH (AUX_FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .push_idx_i (bus.in_aux_res_reg_idx),
    .push_res_i (bus.in_aux_res),
    .pop_i      (pop),
    .kill_vld_i (bus.in_wb_act_write_res_to_reg),
    .kill_idx_i (bus.in_wb_res_reg_idx),
    .ready_o    (fifo_ready),
    .head_vld_o (head_vld),
    .head_live_o(head_live),
    .head_res_o (head_res),
    .head_idx_o (head_idx),
    .mask_o     (fifo_mask)
  );

  // Grant: writeback wins; otherwise a live head writes; a dead head is dropped silently.
  always_comb begin
    wr_en      = 1'b0;
    wr_res     = '0;
    wr_idx     = '0;
    pop        = 1'b0;
    head_grant = 1'b0;
    if (bus.in_wb_act_write_res_to_reg) begin
      wr_en  = 1'b1;
      wr_res = bus.in_wb_res;
      wr_idx = bus.in_wb_res_reg_idx;
      pop    = head_vld && !head_live;
    end else if (head_vld && head_live) begin
      wr_en      = 1'b1;
      wr_res     = head_res;
      wr_idx     = head_idx;
      pop        = 1'b1;
      head_grant = 1'b1;
    end else if (head_vld) begin
      pop = 1'b1;
    end
  end

  // Starvation count: waits of a live head, cleared on grant or empty queue, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!head_vld || head_grant)                 starve_d = '0;
    else if (head_live && (starve_q != LIMIT_C)) starve_d = starve_q + 1'b1;
  end

  // Starvation counter register; stall is decoded straight from it.
  always_ff @(posedge clock) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign bus.out_aux_ready            = fifo_ready && !reset;
  assign bus.out_act_write_res_to_reg = wr_en && !reset;
  assign bus.out_res                  = reset ? '0 : wr_res;
  assign bus.out_res_reg_idx          = reset ? '0 : wr_idx;
  assign bus.out_stall_pipe           = (starve_q == LIMIT_C) && !reset;
  assign bus.out_pending_reg_mask     = reset ? '0 : fifo_mask;

endmodule
